// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: shared FSM state type and default operand width for shift_add_mult.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    localparam int MUL_WIDTH_DEF = 8;

endpackage

// File: rtl/shift_add_mult_step_add.sv
// mul_step_add: one shift-and-add step, hi plus (optionally) the multiplicand, carry kept as MSB.
module mul_step_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, hi} + {1'b0, en ? a : {WIDTH{1'b0}}};

endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned WIDTH x WIDTH multiplier, one add and shift per cycle.
// Define SHIFT_ADD_MULT_OVF_EN to add out_ovf (product does not fit in WIDTH bits).
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef SHIFT_ADD_MULT_OVF_EN
    output logic               out_ovf,
`endif
    output logic [2*WIDTH-1:0] out_prod
);

    mul_state_t         state;
    logic [WIDTH-1:0]   a;
    logic [2*WIDTH-1:0] p;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;

    mul_step_add #(.WIDTH(WIDTH)) u_step (
        .hi (p[2*WIDTH-1:WIDTH]),
        .a  (a),
        .en (p[0]),
        .sum(sum)
    );

    // Multiplier bits drain out of the bottom of p while product bits enter at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a     <= '0;
            p     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= BUSY;
                    a     <= in_a;
                    p     <= {{WIDTH{1'b0}}, in_b};
                    cnt   <= '0;
                end
                BUSY: begin
                    p   <= {sum, p[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_prod  = p;
`ifdef SHIFT_ADD_MULT_OVF_EN
    assign out_ovf   = |p[2*WIDTH-1:WIDTH];
`endif

endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed and randomised checks of shift_add_mult at WIDTH=8 and WIDTH=4.
// Honours SHIFT_ADD_MULT_OVF_EN to also check out_ovf.
module tb_shift_add_mult;

    localparam int W = 8;
    localparam int V = 4;
    localparam int N = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
    logic [W-1:0]   in_a = '0, in_b = '0;
    logic [2*W-1:0] out_prod;
    logic           in_valid4 = 1'b0, out_ready4 = 1'b0, in_ready4, out_valid4;
    logic [V-1:0]   in_a4 = '0, in_b4 = '0;
    logic [2*V-1:0] out_prod4;
`ifdef SHIFT_ADD_MULT_OVF_EN
    logic           out_ovf, out_ovf4;
`endif

    int passes = 0;
    int total = 0;
    logic [2*W-1:0] q8[$];
    logic [2*V-1:0] q4[$];

    shift_add_mult #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef SHIFT_ADD_MULT_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_prod(out_prod)
    );

    shift_add_mult #(.WIDTH(V)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
`ifdef SHIFT_ADD_MULT_OVF_EN
        .out_ovf(out_ovf4),
`endif
        .out_prod(out_prod4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One directed transaction; hold>0 keeps out_ready low for that many cycles in DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [2*W-1:0] e;
        int n;
        e = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        out_ready = (hold == 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        q8.push_back(e);
        tick();
        in_valid = 1'b0;
        in_a = ~a;
        in_b = ~b;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), W);
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            in_a = W'($urandom);
            in_b = W'($urandom);
            tick();
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_prod", 32'(out_prod), 32'(e));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        chk("prod", 32'(out_prod), 32'(q8.pop_front()));
`ifdef SHIFT_ADD_MULT_OVF_EN
        chk("ovf", 32'(out_ovf), 32'(|e[2*W-1:W]));
`endif
        out_ready = 1'b1;
        tick();
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_in_ready", 32'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [2*W-1:0] e8;
        logic [2*V-1:0] e4;
        int acc8, del8, acc4, del4, cyc;
        logic took8, took4;
        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_prod", 32'(out_prod), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        run_op(8'd13, 8'd11, 0);
        run_op(8'd255, 8'd255, 0);
        run_op(8'd0, 8'd200, 0);
        run_op(8'd200, 8'd0, 0);
        run_op(8'd7, 8'd9, 5);

        in_a = 8'd100;
        in_b = 8'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_prod", 32'(out_prod), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        run_op(8'd3, 8'd5, 0);

        acc8 = 0; del8 = 0; acc4 = 0; del4 = 0; cyc = 0;
        took8 = 1'b0; took4 = 1'b0;
        while ((del8 < N || del4 < N) && cyc < 40000) begin
            if (!in_valid || took8) begin
                in_valid = (acc8 < N) && ($urandom_range(0, 3) != 0);
                in_a = W'($urandom);
                in_b = W'($urandom);
            end
            if (!in_valid4 || took4) begin
                in_valid4 = (acc4 < N) && ($urandom_range(0, 3) != 0);
                in_a4 = V'($urandom);
                in_b4 = V'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            out_ready4 = ($urandom_range(0, 3) != 0);
            #2;
            took8 = in_valid && in_ready;
            took4 = in_valid4 && in_ready4;
            if (took8) begin
                q8.push_back({{W{1'b0}}, in_a} * {{W{1'b0}}, in_b});
                acc8++;
            end
            if (took4) begin
                q4.push_back({{V{1'b0}}, in_a4} * {{V{1'b0}}, in_b4});
                acc4++;
            end
            if (out_valid && out_ready) begin
                e8 = (q8.size() != 0) ? q8.pop_front() : 'x;
                chk("rnd8_prod", 32'(out_prod), 32'(e8));
`ifdef SHIFT_ADD_MULT_OVF_EN
                chk("rnd8_ovf", 32'(out_ovf), 32'(|e8[2*W-1:W]));
`endif
                del8++;
            end
            if (out_valid4 && out_ready4) begin
                e4 = (q4.size() != 0) ? q4.pop_front() : 'x;
                chk("rnd4_prod", 32'(out_prod4), 32'(e4));
`ifdef SHIFT_ADD_MULT_OVF_EN
                chk("rnd4_ovf", 32'(out_ovf4), 32'(|e4[2*V-1:V]));
`endif
                del4++;
            end
            tick();
            cyc++;
        end
        chk("rnd8_acc_vs_del", 32'(acc8), 32'(del8));
        chk("rnd4_acc_vs_del", 32'(acc4), 32'(del4));
        chk("rnd8_delivered", 32'(del8), N);
        chk("rnd4_delivered", 32'(del4), N);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
